// File: rtl/quarter_folder_if.sv
// quarter_folder_if: bundles the sample-in and result-out handshakes of the
// quarter folder.
//   in_valid/in_ready/x_in/y_in          : offset-binary sample channel
//   out_valid/out_ready/quarter/x_out/y_out/octant_swap : folded result channel
// Modports:
//   master : the side that sources samples and sinks results (bench / upstream)
//   slave  : the quarter folder itself
interface quarter_folder_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            quarter;
  logic [DATA_WIDTH:0]   x_out;
  logic [DATA_WIDTH:0]   y_out;
  logic                  octant_swap;

  modport master (
    output in_valid,
    output x_in,
    output y_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quarter,
    input  x_out,
    input  y_out,
    input  octant_swap
  );

  modport slave (
    input  in_valid,
    input  x_in,
    input  y_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quarter,
    output x_out,
    output y_out,
    output octant_swap
  );

endinterface

// File: rtl/quarter_folder.sv
// quarter_folder: input side of the CORDIC path. Converts one offset-binary
// (X, Y) sample into a 2-bit quarter code and signed first-quarter magnitudes
// |dx|, |dy| for vectoring-mode CORDIC. The quarter code is the exact inverse
// of the output-side quarter mapper.
//   quarter code: 00 dx>=0,dy>=0 | 01 dx<0,dy>=0 | 10 dx<0,dy<0 | 11 dx>=0,dy<0
// Two-stage valid/ready pipeline (s1: offset removal, s2: fold) with full
// backpressure; in_ready depends combinationally on out_ready only.
// Optional macro QUARTER_FOLDER_OCTANT_EN: stage 2 additionally folds into the
// first octant (swap magnitudes when |dy| > |dx|, flagged on octant_swap).
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous assert, synchronous release, active low
//   bus (slave) : sample and result handshakes, see quarter_folder_if
module quarter_folder #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  quarter_folder_if.slave  bus
);

  localparam int unsigned OUT_WIDTH = DATA_WIDTH + 1;
  localparam logic [OUT_WIDTH-1:0] MID = OUT_WIDTH'(1) << (DATA_WIDTH - 1);

  // Stage 1: centred sample
  logic                 s1_valid;
  logic [OUT_WIDTH-1:0] s1_dx;
  logic [OUT_WIDTH-1:0] s1_dy;

  // Stage 2: folded result, drives the output ports directly
  logic                 s2_valid;
  logic [1:0]           s2_quarter;
  logic [OUT_WIDTH-1:0] s2_x;
  logic [OUT_WIDTH-1:0] s2_y;
  logic                 s2_swap;

  logic                 s2_load;
  logic                 s1_load;

  // Stage-2 fold results (combinational from s1)
  logic                 dx_neg;
  logic                 dy_neg;
  logic [OUT_WIDTH-1:0] abs_dx;
  logic [OUT_WIDTH-1:0] abs_dy;
  logic [1:0]           fold_quarter;
  logic [OUT_WIDTH-1:0] fold_x;
  logic [OUT_WIDTH-1:0] fold_y;
  logic                 fold_swap;

  // Advance rules: a stage moves when it is empty or its successor moves.
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // Stage 1 occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
    end
  end

  // Stage 1 data: remove the offset-binary midpoint; qualified by s1_valid.
  // The zero-extended input minus MID wraps to the correct two's complement.
  always_ff @(posedge clock) begin
    if (bus.in_valid && s1_load) begin
      s1_dx <= {1'b0, bus.x_in} - MID;
      s1_dy <= {1'b0, bus.y_in} - MID;
    end
  end

  // Sign and magnitude; -MID negates to MID, which still fits in OUT_WIDTH.
  assign dx_neg = s1_dx[OUT_WIDTH-1];
  assign dy_neg = s1_dy[OUT_WIDTH-1];
  assign abs_dx = dx_neg ? (OUT_WIDTH'(0) - s1_dx) : s1_dx;
  assign abs_dy = dy_neg ? (OUT_WIDTH'(0) - s1_dy) : s1_dy;

  // Quarter code: MSB = dy negative, LSB = signs differ (zero is non-negative).
  assign fold_quarter = {dy_neg, dx_neg ^ dy_neg};

`ifdef QUARTER_FOLDER_OCTANT_EN
  // First-octant fold: larger magnitude goes to x; ties keep the original order.
  always_comb begin
    fold_x    = abs_dx;
    fold_y    = abs_dy;
    fold_swap = 1'b0;
    if (abs_dy > abs_dx) begin
      fold_x    = abs_dy;
      fold_y    = abs_dx;
      fold_swap = 1'b1;
    end
  end
`else
  // No octant fold: magnitudes pass straight through.
  assign fold_x    = abs_dx;
  assign fold_y    = abs_dy;
  assign fold_swap = 1'b0;
`endif

  // Stage 2 registers; reset so the output ports read 0 during reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      s2_quarter <= 2'b00;
      s2_x       <= '0;
      s2_y       <= '0;
      s2_swap    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_quarter <= fold_quarter;
        s2_x       <= fold_x;
        s2_y       <= fold_y;
        s2_swap    <= fold_swap;
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.quarter     = s2_quarter;
  assign bus.x_out       = s2_x;
  assign bus.y_out       = s2_y;
  assign bus.octant_swap = s2_swap;

endmodule

// File: tb/tb_quarter_folder.sv
// tb_quarter_folder: self-checking bench for quarter_folder (DATA_WIDTH=12).
// Directed table of single samples with exact latency, backpressure burst,
// mid-operation reset, then randomized traffic checked by a scoreboard whose
// reference model works from the centred integer values of each sample.
module tb_quarter_folder;

  localparam int unsigned DW = 12;

  typedef struct packed {
    logic [1:0]  q;
    logic [DW:0] x;
    logic [DW:0] y;
    logic        swap;
  } res_t;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    res_t          exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  quarter_folder_if #(.DATA_WIDTH(DW)) bus ();

  quarter_folder #(.DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: centre, classify by sign, take magnitudes.
  function automatic res_t ref_model(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int dx, dy, ax, ay;
    res_t r;
    dx = int'(x) - (1 << (DW - 1));
    dy = int'(y) - (1 << (DW - 1));
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (dx >= 0 && dy >= 0)     r.q = 2'd0;
    else if (dx < 0 && dy >= 0) r.q = 2'd1;
    else if (dx < 0)            r.q = 2'd2;
    else                        r.q = 2'd3;
    r.x    = (DW + 1)'(ax);
    r.y    = (DW + 1)'(ay);
    r.swap = 1'b0;
`ifdef QUARTER_FOLDER_OCTANT_EN
    if (ay > ax) begin
      r.x    = (DW + 1)'(ay);
      r.y    = (DW + 1)'(ax);
      r.swap = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.q    = bus.quarter;
    r.x    = bus.x_out;
    r.y    = bus.y_out;
    r.swap = bus.octant_swap;
    return r;
  endfunction

  // Scoreboard monitor: samples the handshakes mid-cycle, ahead of the edge.
  res_t exp_q[$];
  int   n_in  = 0;
  int   n_out = 0;
  logic prev_stall = 1'b0;
  res_t prev_out;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
      n_in  = 0;
      n_out = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(cur_out()), 64'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_extra: actual %0h required none", cur_out());
        end else begin
          check("scoreboard", 64'(cur_out()), 64'(exp_q.pop_front()));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_model(bus.x_in, bus.y_in));
        n_in++;
      end
      check("occupancy", 64'((n_in - n_out) <= 2), 64'd1);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = cur_out();
    end
  end

  // One sample into an idle pipeline with out_ready=1: result appears exactly
  // two cycles after the accept cycle and is consumed the cycle after.
  task automatic send_one(input string name, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input res_t exp);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x_in      = x;
    bus.y_in      = y;
    @(negedge clock);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check({name, "_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clock); #1;
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_q"}, 64'(bus.quarter), 64'(exp.q));
    check({name, "_x"}, 64'(bus.x_out), 64'(exp.x));
    check({name, "_y"}, 64'(bus.y_out), 64'(exp.y));
    check({name, "_swap"}, 64'(bus.octant_swap), 64'(exp.swap));
    @(posedge clock); #1;
    check({name, "_once"}, 64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [DW-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return DW'(1 << (DW - 1));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[8];
  logic [DW-1:0] bp_x[8];
  logic [DW-1:0] bp_y[8];
  logic fired;
  int   idx;
  int   base_out;

  initial begin
    tbl[0] = '{12'hA00, 12'h900, '{2'd0, 13'h200, 13'h100, 1'b0}};
    tbl[1] = '{12'h600, 12'h900, '{2'd1, 13'h200, 13'h100, 1'b0}};
    tbl[2] = '{12'h000, 12'h000, '{2'd2, 13'h800, 13'h800, 1'b0}};
`ifdef QUARTER_FOLDER_OCTANT_EN
    tbl[3] = '{12'h800, 12'h7FF, '{2'd3, 13'h001, 13'h000, 1'b1}};
    tbl[5] = '{12'h900, 12'hC00, '{2'd0, 13'h400, 13'h100, 1'b1}};
`else
    tbl[3] = '{12'h800, 12'h7FF, '{2'd3, 13'h000, 13'h001, 1'b0}};
    tbl[5] = '{12'h900, 12'hC00, '{2'd0, 13'h100, 13'h400, 1'b0}};
`endif
    tbl[4] = '{12'hFFF, 12'h800, '{2'd0, 13'h7FF, 13'h000, 1'b0}};
    tbl[6] = '{12'hA00, 12'hA00, '{2'd0, 13'h200, 13'h200, 1'b0}};
    tbl[7] = '{12'h7FF, 12'h801, '{2'd1, 13'h001, 13'h001, 1'b0}};

    for (int i = 0; i < 8; i++) begin
      bp_x[i] = DW'(12'h100 * i + 12'h0F0);
      bp_y[i] = DW'(12'hFFF - 12'h123 * i);
    end

    // Reset state
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quarter", 64'(bus.quarter), 64'd0);
    check("rst_x", 64'(bus.x_out), 64'd0);
    check("rst_y", 64'(bus.y_out), 64'd0);
    check("rst_swap", 64'(bus.octant_swap), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      send_one($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].exp);
    end

    // Backpressure burst: out_ready low for the first 6 cycles
    base_out = n_out;
    fired = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clock); #1;
      if (fired) idx++;
      bus.out_ready = (cyc >= 6);
      bus.in_valid  = (idx < 8);
      if (idx < 8) begin
        bus.x_in = bp_x[idx];
        bus.y_in = bp_y[idx];
      end
      @(negedge clock);
      fired = bus.in_valid && bus.in_ready;
      if (cyc >= 2 && cyc < 6) begin
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_head", 64'(cur_out()), 64'(ref_model(bp_x[0], bp_y[0])));
      end
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("bp_delivered", 64'(n_out - base_out), 64'd8);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two samples in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x_in      = 12'h123;
    bus.y_in      = 12'hABC;
    @(posedge clock); #1;
    bus.x_in      = 12'hDEF;
    bus.y_in      = 12'h456;
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    check("mid_out_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_x", 64'(bus.x_out), 64'd0);
    check("mid_rst_q", 64'(bus.quarter), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    send_one("post_rst", 12'hFFF, 12'h800, '{2'd0, 13'h7FF, 13'h000, 1'b0});

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.x_in      = pick_val();
      bus.y_in      = pick_val();
    end
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_count", 64'(n_in), 64'(n_out));
    check("rand_idle", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
